// File: rtl/buffer_ex_mem.sv
// rtl/buffer_ex_mem.sv - EX->MEM pipeline register with valid/ready handshake and 2-entry skid stage
//
// Holds EX results for the MEM stage. A head entry drives the outputs; a skid
// entry absorbs one extra instruction when MEM stalls, so the upstream ready can
// come from a register instead of combinationally from i_ready.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_valid / o_ready           EX-side handshake
//   i_alu_result, i_store_data,
//   i_address_pc,
//   i_write_address,
//   i_reg_write, i_mem_read,
//   i_mem_write                 EX results for one instruction
//   i_flush                     squash every held entry and any same-cycle accept
//   o_valid / i_ready           MEM-side handshake
//   o_alu_result .. o_mem_write head-entry fields (controls gated by o_valid)
//   o_stall_count               saturating count of cycles with o_valid & ~i_ready
module buffer_ex_mem #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_alu_result,
   input  logic [DATA_W-1:0] i_store_data,
   input  logic [DATA_W-1:0] i_address_pc,
   input  logic [ADDR_W-1:0] i_write_address,
   input  logic              i_reg_write,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic              i_flush,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_alu_result,
   output logic [DATA_W-1:0] o_store_data,
   output logic [DATA_W-1:0] o_address_pc,
   output logic [ADDR_W-1:0] o_write_address,
   output logic              o_reg_write,
   output logic              o_mem_read,
   output logic              o_mem_write,
   output logic [CNT_W-1:0]  o_stall_count
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   ready_q;

   logic accept;
   logic deliver;
   logic load_head_in;
   logic load_head_skid;
   logic load_skid;

   logic [DATA_W-1:0] head_alu, head_sd, head_pc;
   logic [ADDR_W-1:0] head_wa;
   logic              head_rw, head_mr, head_mw;

   logic [DATA_W-1:0] skid_alu, skid_sd, skid_pc;
   logic [ADDR_W-1:0] skid_wa;
   logic              skid_rw, skid_mr, skid_mw;

   logic [CNT_W-1:0]  stall_q;

   // o_valid decodes registered state only, so reset clears it immediately.
   assign o_valid = (state_q != ST_EMPTY);
   assign o_ready = ready_q;
   assign accept  = i_valid & ready_q;
   assign deliver = o_valid & i_ready;

   always_comb begin
      state_d        = state_q;
      load_head_in   = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               load_head_in = 1'b1;
               state_d      = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (accept && deliver) begin
               load_head_in = 1'b1;
            end else if (accept) begin
               load_skid = 1'b1;
               state_d   = ST_FULL;
            end else if (deliver) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // Skid only moves up after the head leaves, preserving program order.
            if (deliver) begin
               load_head_skid = 1'b1;
               state_d        = ST_BUSY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Squash wins over everything, including an instruction accepted this cycle.
      if (i_flush) begin
         state_d        = ST_EMPTY;
         load_head_in   = 1'b0;
         load_head_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d != ST_FULL);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_alu <= '0;
         head_sd  <= '0;
         head_pc  <= '0;
         head_wa  <= '0;
         head_rw  <= 1'b0;
         head_mr  <= 1'b0;
         head_mw  <= 1'b0;
      end else if (load_head_in) begin
         head_alu <= i_alu_result;
         head_sd  <= i_store_data;
         head_pc  <= i_address_pc;
         head_wa  <= i_write_address;
         head_rw  <= i_reg_write;
         head_mr  <= i_mem_read;
         head_mw  <= i_mem_write;
      end else if (load_head_skid) begin
         head_alu <= skid_alu;
         head_sd  <= skid_sd;
         head_pc  <= skid_pc;
         head_wa  <= skid_wa;
         head_rw  <= skid_rw;
         head_mr  <= skid_mr;
         head_mw  <= skid_mw;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_alu <= '0;
         skid_sd  <= '0;
         skid_pc  <= '0;
         skid_wa  <= '0;
         skid_rw  <= 1'b0;
         skid_mr  <= 1'b0;
         skid_mw  <= 1'b0;
      end else if (load_skid) begin
         skid_alu <= i_alu_result;
         skid_sd  <= i_store_data;
         skid_pc  <= i_address_pc;
         skid_wa  <= i_write_address;
         skid_rw  <= i_reg_write;
         skid_mr  <= i_mem_read;
         skid_mw  <= i_mem_write;
      end
   end

   // Flush deliberately leaves the counter alone; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (o_valid && !i_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_alu_result    = head_alu;
   assign o_store_data    = head_sd;
   assign o_address_pc    = head_pc;
   assign o_write_address = head_wa;
   assign o_reg_write     = head_rw & o_valid;
   assign o_mem_read      = head_mr & o_valid;
   assign o_mem_write     = head_mw & o_valid;
   assign o_stall_count   = stall_q;

endmodule

// File: tb/tb_buffer_ex_mem.sv
// tb/tb_buffer_ex_mem.sv - self-checking bench for buffer_ex_mem
module tb_buffer_ex_mem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid, o_ready;
   logic [31:0] i_alu_result, i_store_data, i_address_pc;
   logic [4:0]  i_write_address;
   logic        i_reg_write, i_mem_read, i_mem_write, i_flush;
   logic        o_valid, i_ready;
   logic [31:0] o_alu_result, o_store_data, o_address_pc;
   logic [4:0]  o_write_address;
   logic        o_reg_write, o_mem_read, o_mem_write;
   logic [15:0] o_stall_count;

   always #5 clk = ~clk;

   buffer_ex_mem #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_valid(i_valid), .o_ready(o_ready),
      .i_alu_result(i_alu_result), .i_store_data(i_store_data),
      .i_address_pc(i_address_pc), .i_write_address(i_write_address),
      .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
      .i_flush(i_flush),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_alu_result(o_alu_result), .o_store_data(o_store_data),
      .o_address_pc(o_address_pc), .o_write_address(o_write_address),
      .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
      .o_stall_count(o_stall_count)
   );

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] sd;
      logic [31:0] pc;
      logic [4:0]  wa;
      logic        rw, mr, mw;
   } entry_t;

   typedef struct packed {
      logic   v, r, f;
      entry_t e;
      logic   ev, er;
   } vec_t;

   entry_t q[$];
   int     m_stall;
   int     n_pass  = 0;
   int     n_total = 0;
   vec_t   tbl[23];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mk(input bit v, input bit r, input bit f, input logic [31:0] alu,
                               input logic [4:0] wa, input bit rw, input bit mr, input bit mw,
                               input bit ev, input bit er);
      vec_t t;
      t.v = v; t.r = r; t.f = f;
      t.e.alu = alu; t.e.sd = ~alu; t.e.pc = alu + 32'h400;
      t.e.wa = wa; t.e.rw = rw; t.e.mr = mr; t.e.mw = mw;
      t.ev = ev; t.er = er;
      return t;
   endfunction

   // Drive one cycle at the negedge, check just after, then advance the model at posedge.
   task automatic step(input vec_t t, input bit use_exp, input bit chk);
      bit m_del, m_acc, m_stl;
      i_valid = t.v; i_ready = t.r; i_flush = t.f;
      i_alu_result = t.e.alu; i_store_data = t.e.sd; i_address_pc = t.e.pc;
      i_write_address = t.e.wa;
      i_reg_write = t.e.rw; i_mem_read = t.e.mr; i_mem_write = t.e.mw;
      #1;
      if (chk) begin
         if (use_exp) begin
            check("tbl_valid", {31'd0, o_valid}, {31'd0, t.ev});
            check("tbl_ready", {31'd0, o_ready}, {31'd0, t.er});
         end
         check("sb_valid", {31'd0, o_valid}, {31'd0, q.size() != 0});
         check("sb_ready", {31'd0, o_ready}, {31'd0, q.size() < 2});
         check("stall_count", {16'd0, o_stall_count}, m_stall);
         if (q.size() != 0) begin
            check("alu", o_alu_result, q[0].alu);
            check("store_data", o_store_data, q[0].sd);
            check("pc", o_address_pc, q[0].pc);
            check("wa", {27'd0, o_write_address}, {27'd0, q[0].wa});
            check("ctrl", {29'd0, o_reg_write, o_mem_read, o_mem_write},
                  {29'd0, q[0].rw, q[0].mr, q[0].mw});
         end else begin
            check("ctrl_gated", {29'd0, o_reg_write, o_mem_read, o_mem_write}, 32'd0);
         end
      end
      m_del = (q.size() != 0) && t.r;
      m_acc = t.v && (q.size() < 2);
      m_stl = (q.size() != 0) && !t.r;
      @(posedge clk);
      if (m_stl && m_stall < 65535) m_stall++;
      if (t.f) q.delete();
      else begin
         if (m_del) void'(q.pop_front());
         if (m_acc) q.push_back(t.e);
      end
      @(negedge clk);
   endtask

   vec_t idle_r, idle_s;

   initial begin
      tbl[0]  = mk(1, 1, 0, 32'h10,   5,  1, 0, 0, 0, 1);
      tbl[1]  = mk(0, 1, 0, 32'h0,    0,  0, 0, 0, 1, 1);
      tbl[2]  = mk(0, 1, 0, 32'h0,    0,  0, 0, 0, 0, 1);
      tbl[3]  = mk(1, 1, 0, 32'h101,  1,  1, 0, 0, 0, 1);
      tbl[4]  = mk(1, 1, 0, 32'h102,  2,  0, 1, 0, 1, 1);
      tbl[5]  = mk(1, 1, 0, 32'h103,  3,  0, 0, 1, 1, 1);
      tbl[6]  = mk(1, 1, 0, 32'h104,  4,  1, 1, 0, 1, 1);
      tbl[7]  = mk(0, 1, 0, 32'h0,    0,  0, 0, 0, 1, 1);
      tbl[8]  = mk(0, 1, 0, 32'h0,    0,  0, 0, 0, 0, 1);
      tbl[9]  = mk(1, 0, 0, 32'hA0,   10, 1, 0, 0, 0, 1);
      tbl[10] = mk(1, 0, 0, 32'hB0,   11, 0, 1, 0, 1, 1);
      tbl[11] = mk(1, 0, 0, 32'hC0,   12, 1, 1, 1, 1, 0);
      tbl[12] = mk(0, 1, 0, 32'h0,    0,  0, 0, 0, 1, 0);
      tbl[13] = mk(0, 1, 0, 32'h0,    0,  0, 0, 0, 1, 1);
      tbl[14] = mk(0, 1, 0, 32'h0,    0,  0, 0, 0, 0, 1);
      tbl[15] = mk(1, 0, 0, 32'hD0,   13, 0, 0, 1, 0, 1);
      tbl[16] = mk(1, 0, 0, 32'hE0,   14, 0, 0, 1, 1, 1);
      tbl[17] = mk(1, 0, 1, 32'hF0,   15, 0, 0, 1, 1, 0);
      tbl[18] = mk(0, 1, 0, 32'h0,    0,  0, 0, 0, 0, 1);
      tbl[19] = mk(0, 1, 0, 32'h0,    0,  0, 0, 0, 0, 1);
      tbl[20] = mk(1, 0, 0, 32'h1A0,  16, 1, 0, 0, 0, 1);
      tbl[21] = mk(1, 0, 1, 32'h1B0,  17, 1, 0, 1, 1, 1);
      tbl[22] = mk(0, 1, 0, 32'h0,    0,  0, 0, 0, 0, 1);
      idle_r  = mk(0, 1, 0, 32'h0,    0,  0, 0, 0, 0, 0);
      idle_s  = mk(0, 0, 0, 32'h0,    0,  0, 0, 0, 0, 0);

      m_stall = 0;
      rst_n = 1'b0;
      i_valid = 0; i_ready = 1; i_flush = 0;
      i_alu_result = 0; i_store_data = 0; i_address_pc = 0; i_write_address = 0;
      i_reg_write = 0; i_mem_read = 0; i_mem_write = 0;
      repeat (2) @(negedge clk);
      check("rst_valid", {31'd0, o_valid}, 32'd0);
      check("rst_ready", {31'd0, o_ready}, 32'd1);
      check("rst_alu", o_alu_result, 32'd0);
      check("rst_stall", {16'd0, o_stall_count}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 23; i++) step(tbl[i], 1'b1, 1'b1);
      check("stall_after_table", {16'd0, o_stall_count}, 32'd5);

      // Long stall: counter must saturate at 0xFFFF and not wrap.
      step(mk(1, 0, 0, 32'h5A5A, 7, 1, 0, 1, 0, 1), 1'b0, 1'b1);
      for (int i = 0; i < 70000; i++) step(idle_s, 1'b0, 1'b0);
      step(idle_s, 1'b0, 1'b1);
      check("stall_sat", {16'd0, o_stall_count}, 32'hFFFF);

      // Fill to FULL, then reset mid-cycle: outputs must drop before any clock edge.
      step(mk(1, 0, 0, 32'h6B6B, 8, 1, 1, 0, 0, 1), 1'b0, 1'b1);
      check("full_ready", {31'd0, o_ready}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("async_valid", {31'd0, o_valid}, 32'd0);
      check("async_stall", {16'd0, o_stall_count}, 32'd0);
      check("async_ready", {31'd0, o_ready}, 32'd1);
      check("async_ctrl", {29'd0, o_reg_write, o_mem_read, o_mem_write}, 32'd0);
      q.delete();
      m_stall = 0;
      @(negedge clk);
      rst_n = 1'b1;
      step(idle_r, 1'b0, 1'b1);
      step(idle_r, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
